// File: rtl/upzero_sched.sv
// upzero_sched: round-robin arbiter sharing one upzero core between encoder and decoder.
// Ports: ap_clk/ap_rst clock and sync reset; req_*/dlt_*/done_* per-requester handshake;
// core_start/core_dlt/core_ready core handshake; bank_sel memory-set select;
// busy not idle; err/err_sticky watchdog timeout pulse and latched flag, clr_err clears.
module upzero_sched (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        req_enc,
  input  logic        req_dec,
  input  logic [16:0] dlt_enc,
  input  logic [16:0] dlt_dec,
  output logic        core_start,
  output logic [16:0] core_dlt,
  input  logic        core_ready,
  output logic        bank_sel,
  output logic        done_enc,
  output logic        done_dec,
  output logic        busy,
  output logic        err,
  output logic        err_sticky,
  input  logic        clr_err
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COMPLETE} state_t;
  state_t      state_q, state_d;
  logic        prio_q, prio_d, owner_q, owner_d, to_q, to_d, sticky_q, sticky_d;
  logic        gnt_enc, gnt_dec;
  logic [7:0]  wd_q, wd_d;
  logic [16:0] dlt_q, dlt_d;
  always_comb begin
    gnt_enc  = req_enc && (!req_dec || !prio_q);
    gnt_dec  = req_dec && !gnt_enc;
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    to_d     = to_q;
    wd_d     = wd_q;
    dlt_d    = dlt_q;
    case (state_q)
      IDLE: if (gnt_enc || gnt_dec) begin
        state_d = LAUNCH;
        owner_d = gnt_dec;
        prio_d  = !gnt_dec;
        dlt_d   = gnt_dec ? dlt_dec : dlt_enc;
        to_d    = 1'b0;
      end
      LAUNCH: begin
        state_d = WAIT;
        wd_d    = 8'd0;
      end
      WAIT: begin
        // ready beats a simultaneous timeout
        state_d = (core_ready || wd_q == 8'd200) ? COMPLETE : WAIT;
        to_d    = !core_ready && wd_q == 8'd200;
        wd_d    = (core_ready || wd_q == 8'd200) ? wd_q : wd_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    // a new timeout beats a simultaneous clear
    sticky_d = (state_q == COMPLETE && to_q) || (sticky_q && !clr_err);
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      to_q     <= 1'b0;
      sticky_q <= 1'b0;
      wd_q     <= 8'd0;
      dlt_q    <= 17'd0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      to_q     <= to_d;
      sticky_q <= sticky_d;
      wd_q     <= wd_d;
      dlt_q    <= dlt_d;
    end
  end
  assign core_start = state_q == LAUNCH;
  assign core_dlt   = dlt_q;
  assign bank_sel   = owner_q;
  assign busy       = state_q != IDLE;
  assign done_enc   = state_q == COMPLETE && !owner_q;
  assign done_dec   = state_q == COMPLETE && owner_q;
  assign err        = state_q == COMPLETE && to_q;
  assign err_sticky = sticky_q;
endmodule

// File: tb/tb_upzero_sched.sv
// tb_upzero_sched: directed table and sequence checks for upzero_sched.
module tb_upzero_sched;
  logic        ap_clk = 1'b0, ap_rst, req_enc, req_dec, core_ready, clr_err;
  logic [16:0] dlt_enc, dlt_dec, core_dlt;
  logic        core_start, bank_sel, done_enc, done_dec, busy, err, err_sticky;
  int          n_chk = 0, n_fail = 0, n_both = 0;
  typedef struct {
    logic        re, rd;
    logic [16:0] de, dd;
    int          dly;
    logic        own;
    logic [16:0] edlt;
    logic        eprio;
  } vec_t;
  vec_t v[7];
  always #5 ap_clk = ~ap_clk;
  upzero_sched dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_enc(req_enc), .req_dec(req_dec),
    .dlt_enc(dlt_enc), .dlt_dec(dlt_dec), .core_start(core_start), .core_dlt(core_dlt),
    .core_ready(core_ready), .bank_sel(bank_sel), .done_enc(done_enc), .done_dec(done_dec),
    .busy(busy), .err(err), .err_sticky(err_sticky), .clr_err(clr_err)
  );
  always @(posedge ap_clk) if (done_enc && done_dec) n_both++;
  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic pass(input vec_t t);
    req_enc = t.re;
    req_dec = t.rd;
    dlt_enc = t.de;
    dlt_dec = t.dd;
    tick;
    chk("start", core_start, 1);
    chk("dlt", core_dlt, t.edlt);
    chk("bank", bank_sel, t.own);
    chk("prio", dut.prio_q, t.eprio);
    dlt_enc = ~t.de;
    dlt_dec = ~t.dd;
    for (int i = 0; i < t.dly; i++) begin
      tick;
      chk("wait_start", core_start, 0);
      chk("wait_done", done_enc | done_dec, 0);
    end
    chk("hold_dlt", core_dlt, t.edlt);
    chk("hold_bank", bank_sel, t.own);
    core_ready = 1;
    tick;
    core_ready = 0;
    chk("done_enc", done_enc, !t.own);
    chk("done_dec", done_dec, t.own);
    chk("err", err, 0);
    if (t.own) req_dec = 0; else req_enc = 0;
    tick;
    chk("idle", busy, 0);
  endtask
  task automatic do_reset;
    req_enc = 0;
    req_dec = 0;
    core_ready = 0;
    clr_err = 0;
    ap_rst = 1;
    tick;
    ap_rst = 0;
  endtask
  initial begin
    dlt_enc = 0;
    dlt_dec = 0;
    do_reset;
    chk("rst_start", core_start, 0);
    chk("rst_dlt", core_dlt, 0);
    chk("rst_bank", bank_sel, 0);
    chk("rst_done", {done_enc, done_dec}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err, err_sticky}, 0);
    chk("rst_prio", dut.prio_q, 0);
    v[0] = '{1, 0, 17'h1FF85, 17'h00001, 5, 0, 17'h1FF85, 1};
    v[1] = '{1, 1, 17'h0FFFF, 17'h10000, 1, 1, 17'h10000, 0};
    v[2] = '{1, 1, 17'h00000, 17'h1FFFF, 3, 0, 17'h00000, 1};
    v[3] = '{1, 0, 17'h12345, 17'h0ABCD, 2, 0, 17'h12345, 1};
    v[4] = '{1, 1, 17'h1AAAA, 17'h05555, 6, 1, 17'h05555, 0};
    v[5] = '{0, 1, 17'h00000, 17'h08000, 4, 1, 17'h08000, 0};
    v[6] = '{1, 1, 17'h0F0F0, 17'h10F0F, 1, 0, 17'h0F0F0, 1};
    for (int k = 0; k < 7; k++) pass(v[k]);
    do_reset;
    req_enc = 1;
    req_dec = 1;
    tick;
    chk("rr1_bank", bank_sel, 0);
    chk("rr1_prio", dut.prio_q, 1);
    tick;
    core_ready = 1;
    tick;
    core_ready = 0;
    chk("rr1_done", {done_enc, done_dec}, 2'b10);
    req_enc = 0;
    tick;
    tick;
    chk("rr2_start", core_start, 1);
    chk("rr2_bank", bank_sel, 1);
    chk("rr2_prio", dut.prio_q, 0);
    tick;
    core_ready = 1;
    tick;
    core_ready = 0;
    chk("rr2_done", {done_enc, done_dec}, 2'b01);
    req_dec = 0;
    tick;
    req_enc = 1;
    tick;
    chk("to_start", core_start, 1);
    for (int i = 0; i < 201; i++) tick;
    chk("to_pre", {done_enc, err}, 0);
    tick;
    chk("to_done", done_enc, 1);
    chk("to_err", err, 1);
    req_enc = 0;
    tick;
    chk("to_err_pulse", err, 0);
    chk("to_sticky", err_sticky, 1);
    tick;
    tick;
    chk("to_sticky_hold", err_sticky, 1);
    clr_err = 1;
    tick;
    clr_err = 0;
    chk("to_clr", err_sticky, 0);
    clr_err = 1;
    req_enc = 1;
    tick;
    for (int i = 0; i < 202; i++) tick;
    chk("to2_err", err, 1);
    req_enc = 0;
    tick;
    chk("set_wins", err_sticky, 1);
    tick;
    chk("clr_held", err_sticky, 0);
    clr_err = 0;
    req_enc = 1;
    tick;
    for (int i = 0; i < 201; i++) tick;
    chk("co_pre", {busy, done_enc}, 2'b10);
    core_ready = 1;
    tick;
    core_ready = 0;
    chk("co_done", done_enc, 1);
    chk("co_err", err, 0);
    req_enc = 0;
    tick;
    chk("co_sticky", err_sticky, 0);
    core_ready = 1;
    tick;
    chk("sp_idle", {busy, done_enc, done_dec}, 0);
    req_enc = 1;
    tick;
    chk("sp_start", core_start, 1);
    tick;
    core_ready = 0;
    chk("sp_launch", {busy, core_start, done_enc, done_dec}, 4'b1000);
    tick;
    chk("sp_wait", {busy, done_enc}, 2'b10);
    core_ready = 1;
    tick;
    core_ready = 0;
    chk("sp_done", done_enc, 1);
    req_enc = 0;
    tick;
    req_dec = 1;
    tick;
    chk("ab_bank", bank_sel, 1);
    tick;
    tick;
    tick;
    ap_rst = 1;
    tick;
    chk("ab_busy", busy, 0);
    chk("ab_start", core_start, 0);
    chk("ab_bank0", bank_sel, 0);
    chk("ab_dlt", core_dlt, 0);
    chk("ab_done", {done_enc, done_dec}, 0);
    ap_rst = 0;
    req_dec = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("ab_no_done", {done_enc, done_dec, busy}, 0);
    end
    req_enc = 1;
    tick;
    chk("post_rst_start", core_start, 1);
    tick;
    core_ready = 1;
    tick;
    core_ready = 0;
    chk("post_rst_done", done_enc, 1);
    req_enc = 0;
    tick;
    chk("both_done", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
